// File: rtl/rob_commit.sv
// In-order retirement stage: pops ready ROB head entries, writes the register
// file one cycle later, and issues stores through a single-outstanding handshake.
package rob_commit_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic            valid;
    logic            wr_mem;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] dest_addr;
  } ROB_ENTRY;
endpackage

module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned STORE_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  ROB_ENTRY             head_entry,
  input  logic                 head_ready,
  output logic                 rob_pop,
  output logic                 rf_wr_en,
  output logic [4:0]           rf_wr_idx,
  output logic [XLEN-1:0]      rf_wr_data,
  output logic                 mem_req_valid,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic [XLEN-1:0]      mem_req_data,
  input  logic                 mem_req_ready,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic                 mem_err
);

  localparam int unsigned TW = $clog2(STORE_TIMEOUT + 1);

  typedef enum logic {RUN, ST_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          commit;

  assign commit = head_entry.valid && head_ready;

  always_comb begin
    rob_pop = 1'b0;
    if (reset) begin
      case (state)
        RUN:     rob_pop = commit && !head_entry.wr_mem;
        ST_WAIT: rob_pop = mem_req_ready;
        default: rob_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      rf_wr_en      <= 1'b0;
      rf_wr_idx     <= '0;
      rf_wr_data    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      retired_count <= '0;
      mem_err       <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      case (state)
        RUN: begin
          if (commit && !head_entry.wr_mem) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
            if (head_entry.dest_reg != ZERO_REG) begin
              rf_wr_en   <= 1'b1;
              rf_wr_idx  <= head_entry.dest_reg;
              rf_wr_data <= head_entry.value;
            end
          end else if (commit) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= head_entry.dest_addr;
            mem_req_data  <= head_entry.value;
            tmo_cnt       <= '0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            retired_count <= retired_count + CNT_WIDTH'(1);
            state         <= RUN;
          end else begin
            if (tmo_cnt != TW'(STORE_TIMEOUT))
              tmo_cnt <= tmo_cnt + TW'(1);
            // error raised on the same edge the counter reaches the limit
            if (tmo_cnt >= TW'(STORE_TIMEOUT - 1))
              mem_err <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a queue-based model.
module tb_rob_commit;
  import rob_commit_pkg::*;

  localparam int unsigned CW  = 8;
  localparam int unsigned TMO = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  ROB_ENTRY        head_entry = '0;
  logic            head_ready = 1'b0;
  logic            rob_pop;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_idx;
  logic [XLEN-1:0] rf_wr_data;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_data;
  logic            mem_req_ready = 1'b0;
  logic [CW-1:0]   retired_count;
  logic            mem_err;

  rob_commit #(.CNT_WIDTH(CW), .STORE_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .head_entry(head_entry), .head_ready(head_ready),
    .rob_pop(rob_pop), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .retired_count(retired_count), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an outstanding store is an entry in a queue of depth <= 1.
  typedef struct { logic [XLEN-1:0] addr; logic [XLEN-1:0] data; } store_t;
  store_t          st_q[$];
  int              m_waited;
  bit              m_err;
  int unsigned     m_count;
  bit              m_rf_en;
  logic [4:0]      m_rf_idx;
  logic [XLEN-1:0] m_rf_data;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q.delete();
      m_waited = 0; m_err = 0; m_count = 0;
      m_rf_en = 0; m_rf_idx = '0; m_rf_data = '0;
    end else begin
      m_rf_en = 0;
      if (st_q.size() != 0) begin
        if (mem_req_ready) begin
          void'(st_q.pop_front());
          m_count++;
        end else begin
          m_waited++;
          if (m_waited >= int'(TMO)) m_err = 1;
        end
      end else if (head_entry.valid && head_ready) begin
        if (head_entry.wr_mem) begin
          st_q.push_back('{addr: head_entry.dest_addr, data: head_entry.value});
          m_waited = 0;
        end else begin
          m_count++;
          if (head_entry.dest_reg != 5'd0) begin
            m_rf_en = 1; m_rf_idx = head_entry.dest_reg; m_rf_data = head_entry.value;
          end
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_pop", rob_pop, 0);
      chk("rst_outs", {rf_wr_en, rf_wr_idx, rf_wr_data, mem_req_valid, mem_err, retired_count}, 0);
    end else begin
      bit exp_pop;
      exp_pop = (st_q.size() != 0) ? mem_req_ready
              : (head_entry.valid && head_ready && !head_entry.wr_mem);
      chk("rob_pop", rob_pop, exp_pop);
      if (rob_pop) chk("pop_needs_valid", head_entry.valid, 1);
      chk("rf_wr_en", rf_wr_en, m_rf_en);
      if (m_rf_en) begin
        chk("rf_wr_idx", rf_wr_idx, m_rf_idx);
        chk("rf_wr_data", rf_wr_data, m_rf_data);
      end
      chk("mem_req_valid", mem_req_valid, st_q.size() != 0);
      if (st_q.size() != 0) begin
        chk("mem_req_addr", mem_req_addr, st_q[0].addr);
        chk("mem_req_data", mem_req_data, st_q[0].data);
      end
      chk("retired_count", retired_count, m_count % (1 << CW));
      chk("mem_err", mem_err, m_err);
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic set_head(input bit v, input bit st, input logic [4:0] rd,
                          input logic [XLEN-1:0] val, input logic [XLEN-1:0] addr, input bit rdy);
    head_entry.valid = v; head_entry.wr_mem = st; head_entry.dest_reg = rd;
    head_entry.value = val; head_entry.dest_addr = addr; head_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b0; head_entry = '0; head_ready = 0; mem_req_ready = 0;
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("lit_reset_count", retired_count, 0);

    // 1: non-store commit
    set_head(1, 0, 5'd3, 32'd5, 32'd0, 1); #1;
    chk("lit_t1_pop", rob_pop, 1);
    step(); set_head(0, 0, 0, 0, 0, 0);
    chk("lit_t1_en", rf_wr_en, 1);
    chk("lit_t1_idx", rf_wr_idx, 3);
    chk("lit_t1_data", rf_wr_data, 5);
    chk("lit_t1_count", retired_count, 1);

    // 2: zero register
    set_head(1, 0, 5'd0, 32'd7, 32'd0, 1); #1;
    chk("lit_t2_pop", rob_pop, 1);
    step(); set_head(0, 0, 0, 0, 0, 0);
    chk("lit_t2_en", rf_wr_en, 0);
    chk("lit_t2_count", retired_count, 2);

    // 3: store with delayed accept; head changes during the wait
    set_head(1, 1, 5'd0, 32'd10, 32'd11, 1); #1;
    chk("lit_t3_nopop", rob_pop, 0);
    step();
    for (int unsigned i = 0; i < 4; i++) begin
      set_head(1, 1, 5'd9, 32'h100 + i, 32'h200 + i, 1);
      mem_req_ready = (i == 3); #1;
      chk("lit_t3_valid", mem_req_valid, 1);
      chk("lit_t3_addr", mem_req_addr, 11);
      chk("lit_t3_data", mem_req_data, 10);
      chk("lit_t3_pop", rob_pop, i == 3);
      step();
    end
    set_head(0, 0, 0, 0, 0, 0); mem_req_ready = 0;
    chk("lit_t3_valid_off", mem_req_valid, 0);
    chk("lit_t3_count", retired_count, 3);

    // 4: back-to-back
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      set_head(1, 0, 5'(i + 1), 32'(i + 20), 0, 1); step();
      chk("lit_t4_rf", {rf_wr_en, rf_wr_idx}, {1'b1, 5'(i + 1)});
    end
    set_head(1, 1, 0, 32'd33, 32'd44, 1); step();
    mem_req_ready = 1; #1;
    chk("lit_t4_st_pop", rob_pop, 1);
    step(); mem_req_ready = 0;
    set_head(1, 0, 5'd7, 32'd77, 0, 1); #1;
    chk("lit_t4_next_pop", rob_pop, 1);
    step(); set_head(0, 0, 0, 0, 0, 0);
    chk("lit_t4_count", retired_count, 5);

    // 5: timeout
    do_reset();
    set_head(1, 1, 0, 32'd1, 32'd2, 1); step();
    for (int unsigned i = 1; i <= 6; i++) begin
      step();
      chk("lit_t5_err", mem_err, i >= TMO);
    end
    mem_req_ready = 1; step(); mem_req_ready = 0; set_head(0, 0, 0, 0, 0, 0);
    chk("lit_t5_accepted", mem_req_valid, 0);
    chk("lit_t5_err_sticky", mem_err, 1);
    chk("lit_t5_count", retired_count, 1);

    // 6: reset mid-store, off-edge
    set_head(1, 1, 0, 32'hAA, 32'hBB, 1); step(); step();
    #2 reset = 0; #1;
    chk("lit_t6_valid", mem_req_valid, 0);
    chk("lit_t6_err", mem_err, 0);
    chk("lit_t6_count", retired_count, 0);
    step(); reset = 1;
    set_head(1, 1, 0, 32'hCC, 32'hDD, 1); step();
    chk("lit_t6_reissue", {mem_req_valid, mem_req_addr, mem_req_data}, {1'b1, 32'hDD, 32'hCC});
    mem_req_ready = 1; step(); mem_req_ready = 0; set_head(0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model; occasional off-edge resets
    for (int unsigned c = 0; c < 4000; c++) begin
      ROB_ENTRY e;
      e.valid     = ($urandom_range(0, 9) < 8) || (st_q.size() != 0);
      e.wr_mem    = ($urandom_range(0, 9) < 3);
      e.dest_reg  = 5'($urandom_range(0, 7));
      e.value     = $urandom;
      e.dest_addr = $urandom;
      head_entry  = e;
      head_ready  = ($urandom_range(0, 9) < 7);
      mem_req_ready = (c % 500 < 40) ? 1'b0 : ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 0; #1 reset = 1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order retirement stage directly downstream of the ROB.
- Consumes the ROB head entry and ready flag. For a ready non-store it pops the head and writes the register file one cycle later.
- For a ready store it issues a single memory write request with a valid/ready handshake and pops the head only when memory accepts the request.
- Also keeps a retired-instruction counter and flags a sticky store-timeout error.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.
- STORE_TIMEOUT, 64, number of ST_WAIT cycles without mem_req_ready before mem_err sets.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- head_entry  input  ROB_ENTRY  ROB head entry; fields used: valid, wr_mem, dest_reg, value, dest_addr.
- head_ready  input  1  head entry fully resolved; for stores, both value and address are ready.
- rob_pop  output  1  combinational; retire and advance the ROB head at this posedge.
- rf_wr_en  output  1  registered register-file write enable.
- rf_wr_idx  output  5  registered destination register.
- rf_wr_data  output  XLEN  registered write data.
- mem_req_valid  output  1  registered store request valid.
- mem_req_addr  output  XLEN  store address, latched.
- mem_req_data  output  XLEN  store data, latched.
- mem_req_ready  input  1  memory accepts the request at this posedge when valid is high.
- retired_count  output  CNT_WIDTH  total committed instructions; wraps modulo 2^CNT_WIDTH.
- mem_err  output  1  sticky store-timeout flag.

Behaviour:
- Reset (reset==0, async):
  - state=RUN.
  - rf_wr_en=0, rf_wr_idx=0, rf_wr_data=0.
  - mem_req_valid=0, mem_req_addr=0, mem_req_data=0.
  - retired_count=0, mem_err=0, timeout counter=0.
  - rob_pop=0 while reset is asserted.
  - A reset during ST_WAIT drops mem_req_valid immediately; the store is abandoned and is not counted.
- States: RUN, ST_WAIT.
- RUN, commit = head_entry.valid && head_ready:
  - commit && !wr_mem:
    - rob_pop=1 this cycle.
    - Next cycle: rf_wr_en=1, rf_wr_idx=dest_reg, rf_wr_data=value.
    - If dest_reg==ZERO_REG, rf_wr_en stays 0; the instruction still pops and counts.
    - retired_count+1. Stay in RUN.
  - commit && wr_mem:
    - rob_pop=0.
    - Latch mem_req_addr=dest_addr and mem_req_data=value.
    - mem_req_valid=1 from the next cycle. Go to ST_WAIT; timeout counter=0.
  - !commit: rob_pop=0; rf_wr_en=0 next cycle.
  - Non-store commits may occur every cycle, one per cycle.
- ST_WAIT:
  - mem_req_valid, addr and data are held stable until accepted. head_entry is ignored; the latched copy is authoritative.
  - rob_pop = mem_req_ready (combinational).
  - On a posedge with mem_req_ready=1: mem_req_valid=0, retired_count+1, go to RUN.
  - The head may not commit in the same cycle as the store pop. The next head is evaluated in the following cycle.
  - Otherwise the timeout counter increments and saturates at STORE_TIMEOUT. When it reaches STORE_TIMEOUT, mem_err=1; mem_err clears only on reset.
  - ST_WAIT does not exit on timeout.
  - rf_wr_en=0 throughout ST_WAIT, and in the first cycle after entering it.
- Outstanding requests: at most one at any time.
- Invariant: rob_pop is never high while head_entry.valid==0.
- retired_count wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
1. Non-store commit: after reset, head={valid=1, wr_mem=0, dest_reg=3, value=5}, head_ready=1 for one cycle.
   -> rob_pop=1 that cycle. Next cycle rf_wr_en=1, idx=3, data=5. retired_count=1.
2. Zero register: head with dest_reg=0, value=7, ready.
   -> rob_pop=1, rf_wr_en stays 0, retired_count increments.
3. Store with delayed accept: head={wr_mem=1, dest_addr=11, value=10}, ready; mem_req_ready held 0 for 3 cycles, then 1.
   -> mem_req_valid=1 with addr=11, data=10 stable for 4 cycles.
   -> rob_pop=1 only in the accepting cycle; valid=0 next cycle; count+1.
   -> Changing head_entry during the wait does not alter addr or data.
4. Back-to-back: 3 ready non-stores on consecutive cycles, then a store accepted immediately, then a non-store.
   -> 3 consecutive pops and rf writes.
   -> Store issues, pops in the accept cycle, and the following non-store pops in the next cycle.
   -> retired_count=5.
5. Timeout: STORE_TIMEOUT=4; store issued and mem_req_ready held 0.
   -> mem_err=1 after 4 wait cycles and stays 1 after a later accept.
   -> The request is still accepted normally.
6. Reset mid-store: assert reset=0 asynchronously (off-edge) while in ST_WAIT.
   -> mem_req_valid=0 immediately; all outputs at reset values.
   -> After release, a new ready store re-issues with the new addr and data.
